// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type, instruction-cache field layout and FSM state encoding.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Default instruction-cache geometry; icache re-derives its widths from its own SETS.
    localparam int unsigned ISETS  = 16;
    localparam int unsigned IIDX_W = $clog2(ISETS);
    localparam int unsigned ITAG_W = 32 - IIDX_W - 2;

    typedef struct packed {
        logic [ITAG_W-1:0] tag;
        logic [IIDX_W-1:0] idx;
        logic [1:0]        bytoff;
    } icachef_t;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with zero-latency hits.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache
    import cpu_types_pkg::*;
#(
    parameter int unsigned SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned TAG_W = 30 - IDX_W;

    icache_state_t state, state_n;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tags  [SETS];
    word_t            data  [SETS];
    word_t            miss_addr;

    logic [IDX_W-1:0] idx, fill_idx;
    logic [TAG_W-1:0] tag, fill_tag;
    logic             hit;
    logic             fill_we;
    logic             miss_start;
    logic             unused_ok;

    assign idx       = imemaddr[IDX_W+1:2];
    assign tag       = imemaddr[31:IDX_W+2];
    assign fill_idx  = miss_addr[IDX_W+1:2];
    assign fill_tag  = miss_addr[31:IDX_W+2];
    assign unused_ok = ^{imemaddr[1:0], miss_addr[1:0]};

    assign hit = imemREN && valid[idx] && (tags[idx] == tag);

    always_comb begin
        state_n    = state;
        ihit       = 1'b0;
        imemload   = '0;
        iREN       = 1'b0;
        iaddr      = '0;
        fill_we    = 1'b0;
        miss_start = 1'b0;
        unique case (state)
            IDLE: begin
                if (hit) begin
                    ihit     = 1'b1;
                    imemload = data[idx];
                end else if (imemREN) begin
                    miss_start = 1'b1;
                    state_n    = FILL;
                end
            end
            FILL: begin
                // Fill runs to completion regardless of imemREN/imemaddr changes.
                iREN  = 1'b1;
                iaddr = miss_addr;
                if (!iwait) begin
                    fill_we = 1'b1;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state     <= IDLE;
            valid     <= '0;
            miss_addr <= '0;
        end else begin
            state <= state_n;
            if (miss_start)
                miss_addr <= imemaddr;
            if (fill_we)
                valid[fill_idx] <= 1'b1;
        end
    end

    // Tag and data need no reset: valid bits gate every use.
    always_ff @(posedge CLK) begin
        if (nRST && fill_we) begin
            tags[fill_idx] <= fill_tag;
            data[fill_idx] <= iload;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_cnt, miss_cnt;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (state == IDLE && hit)
                hit_cnt <= hit_cnt + 32'd1;
            if (miss_start)
                miss_cnt <= miss_cnt + 32'd1;
        end
    end

    assign hit_count  = hit_cnt;
    assign miss_count = miss_cnt;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule
